// File: rtl/fpnew_f2icast_if.sv
// ---------------------------------------------------------------------------
// fpnew_f2icast_if
//   Bundles the operation-side and result-side handshake signals of the
//   FP32 -> int32/uint32 cast unit.
//
//   master : the side that issues operations and consumes results
//   slave  : the cast unit itself
//
//   Signals
//     operand, rnd_mode, op_mod, in_tag : operation payload
//     in_valid / in_ready               : operation handshake
//     flush                             : discard everything in flight
//     result, status, out_tag           : result payload
//     out_valid / out_ready             : result handshake
//     busy                              : any pipeline stage occupied
// ---------------------------------------------------------------------------
interface fpnew_f2icast_if #(
  parameter type TagType = logic
) ();

  logic [31:0] operand;
  logic [2:0]  rnd_mode;
  logic        op_mod;
  TagType      in_tag;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] result;
  logic [4:0]  status;
  TagType      out_tag;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output operand, rnd_mode, op_mod, in_tag, in_valid, flush, out_ready,
    input  in_ready, result, status, out_tag, out_valid, busy
  );

  modport slave (
    input  operand, rnd_mode, op_mod, in_tag, in_valid, flush, out_ready,
    output in_ready, result, status, out_tag, out_valid, busy
  );

endinterface

// File: rtl/fpnew_f2icast.sv
// ---------------------------------------------------------------------------
// fpnew_f2icast
//   Three-stage pipelined FP32 -> int32 / uint32 conversion.
//
//   S1 : unpack and classify the operand (zero/subnormal, normal, Inf, NaN),
//        compute the unbiased exponent.
//   S2 : align the significand into a 33-bit integer magnitude plus round
//        and sticky bits.
//   S3 : round per mode, saturate, apply sign, produce status flags.
//
//   Each stage has its own valid bit and advances when it is empty or the
//   following stage accepts, so the pipeline holds up to three operations
//   under backpressure and streams one per cycle otherwise.
//
//   Ports
//     clk_i        clock, rising edge
//     rst_ni       synchronous active-low reset
//     operand_i    FP32 source operand
//     rnd_mode_i   0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, others RNE
//     op_mod_i     0 signed int32, 1 unsigned uint32
//     tag_i        opaque tag carried with the operation
//     in_valid_i   / in_ready_o   operation handshake
//     flush_i      discard all operations in flight
//     result_o     integer result
//     status_o     {NV, DZ, OF, UF, NX}
//     tag_o        tag of the result currently presented
//     out_valid_o  / out_ready_i  result handshake
//     busy_o       any stage holds a valid operation
// ---------------------------------------------------------------------------
module fpnew_f2icast #(
  parameter type TagType = logic
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] operand_i,
  input  logic [2:0]  rnd_mode_i,
  input  logic        op_mod_i,
  input  TagType      tag_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic [4:0]  status_o,
  output TagType      tag_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_e;

  // -------------------------------------------------------------------------
  // Pipeline control
  // -------------------------------------------------------------------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_en, s2_en, s3_en;

  assign s3_en       = !s3_valid || out_ready_i;
  assign s2_en       = !s2_valid || s3_en;
  assign s1_en       = !s1_valid || s2_en;
  assign in_ready_o  = s1_en;
  assign out_valid_o = s3_valid;
  assign busy_o      = s1_valid || s2_valid || s3_valid;

  // NOTE: only the valid bits are reset; the payload registers below are
  // qualified by them, so clearing the payload would add reset fan-out for
  // no functional gain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= in_valid_i;
      if (s2_en) s2_valid <= s1_valid;
      if (s3_en) s3_valid <= s2_valid;
    end
  end

  // -------------------------------------------------------------------------
  // S1: unpack / classify
  // -------------------------------------------------------------------------
  logic              s1_sign;
  logic signed [9:0] s1_exp;     // unbiased exponent
  logic [23:0]       s1_mant;    // significand with hidden bit
  logic              s1_nan;
  logic              s1_inf;
  logic              s1_tiny;    // zero or subnormal: magnitude below 1
  rnd_e              s1_rnd;
  logic              s1_op_mod;
  TagType            s1_tag;

  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  assign in_exp  = operand_i[30:23];
  assign in_frac = operand_i[22:0];

  always_ff @(posedge clk_i) begin
    if (s1_en && in_valid_i) begin
      s1_sign   <= operand_i[31];
      s1_exp    <= $signed({2'b00, in_exp}) - 10'sd127;
      s1_mant   <= {in_exp != 8'd0, in_frac};
      s1_nan    <= (in_exp == 8'hFF) && (in_frac != 23'd0);
      s1_inf    <= (in_exp == 8'hFF) && (in_frac == 23'd0);
      s1_tiny   <= (in_exp == 8'd0);
      s1_rnd    <= rnd_e'(rnd_mode_i);
      s1_op_mod <= op_mod_i;
      s1_tag    <= tag_i;
    end
  end

  // -------------------------------------------------------------------------
  // S2: alignment
  //   For exponents in [-1, 32] the significand is shifted left by (e + 1),
  //   which places the binary point 24 bits up from the LSB: bits [56:24]
  //   are the integer magnitude, bit 23 the round bit, [22:0] the sticky
  //   field. Larger exponents cannot fit any result range; smaller ones
  //   leave only a nonzero sticky.
  // -------------------------------------------------------------------------
  logic [56:0] align_shifted;
  logic [5:0]  align_shamt;
  logic [32:0] align_int;
  logic        align_round;
  logic        align_sticky;
  logic        align_huge;

  // NOTE: every always_comb output receives a default first, so no path
  // through the branches can leave a value held and infer a latch.
  always_comb begin
    align_shifted = '0;
    align_shamt   = '0;
    align_int     = '0;
    align_round   = 1'b0;
    align_sticky  = 1'b0;
    align_huge    = s1_inf;
    if (s1_nan || s1_inf) begin
      // Handled entirely in S3.
    end else if (s1_tiny) begin
      align_sticky = |s1_mant;
    end else if (s1_exp > 10'sd32) begin
      align_huge = 1'b1;
    end else if (s1_exp < -10'sd1) begin
      align_sticky = 1'b1;
    end else begin
      align_shamt   = 6'(s1_exp + 10'sd1);
      align_shifted = 57'(s1_mant) << align_shamt;
      align_int     = align_shifted[56:24];
      align_round   = align_shifted[23];
      align_sticky  = |align_shifted[22:0];
    end
  end

  logic        s2_sign;
  logic [32:0] s2_int;
  logic        s2_round;
  logic        s2_sticky;
  logic        s2_nan;
  logic        s2_huge;
  rnd_e        s2_rnd;
  logic        s2_op_mod;
  TagType      s2_tag;

  always_ff @(posedge clk_i) begin
    if (s2_en && s1_valid) begin
      s2_sign   <= s1_sign;
      s2_int    <= align_int;
      s2_round  <= align_round;
      s2_sticky <= align_sticky;
      s2_nan    <= s1_nan;
      s2_huge   <= align_huge;
      s2_rnd    <= s1_rnd;
      s2_op_mod <= s1_op_mod;
      s2_tag    <= s1_tag;
    end
  end

  // -------------------------------------------------------------------------
  // S3: round, saturate, apply sign
  // -------------------------------------------------------------------------
  logic        round_up;
  logic        inexact;
  logic [33:0] rounded;
  logic        out_of_range;
  logic        invalid;
  logic [31:0] cast_result;
  logic [4:0]  cast_status;

  always_comb begin
    inexact = s2_round || s2_sticky;
    case (s2_rnd)
      RTZ:     round_up = 1'b0;
      RDN:     round_up = s2_sign && inexact;
      RUP:     round_up = !s2_sign && inexact;
      RMM:     round_up = s2_round;
      default: round_up = s2_round && (s2_sticky || s2_int[0]);
    endcase

    rounded = {1'b0, s2_int} + 34'(round_up);

    // A negative unsigned cast is legal only when it rounds to zero; the
    // signed negative limit is one larger than the positive one.
    if (s2_op_mod) begin
      out_of_range = s2_sign ? (rounded != 34'd0) : (rounded > 34'hFFFF_FFFF);
    end else begin
      out_of_range = s2_sign ? (rounded > 34'h8000_0000) : (rounded > 34'h7FFF_FFFF);
    end

    invalid     = s2_nan || s2_huge || out_of_range;
    cast_result = rounded[31:0];
    if (s2_nan || (invalid && !s2_sign)) begin
      cast_result = s2_op_mod ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (invalid) begin
      cast_result = s2_op_mod ? 32'h0000_0000 : 32'h8000_0000;
    end else if (s2_sign) begin
      // Two's complement of the magnitude; 2^31 maps onto itself.
      cast_result = s2_op_mod ? 32'd0 : (32'd0 - rounded[31:0]);
    end

    cast_status = {invalid, 3'b000, !invalid && inexact};
  end

  TagType s3_tag;

  always_ff @(posedge clk_i) begin
    if (s3_en && s2_valid) begin
      result_o <= cast_result;
      status_o <= cast_status;
      s3_tag   <= s2_tag;
    end
  end

  assign tag_o = s3_tag;

endmodule

// File: tb/tb_fpnew_f2icast.sv
// ---------------------------------------------------------------------------
// tb_fpnew_f2icast
//   Directed vectors with hand-computed results. The driver pushes the
//   expected result of every accepted operation into a queue; an independent
//   monitor pops and compares whenever a result is handed off.
// ---------------------------------------------------------------------------
module tb_fpnew_f2icast;

  typedef logic [7:0] tag_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  st;
    tag_t        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fpnew_f2icast_if #(.TagType(tag_t)) bus ();

  fpnew_f2icast #(.TagType(tag_t)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .operand_i  (bus.operand),
    .rnd_mode_i (bus.rnd_mode),
    .op_mod_i   (bus.op_mod),
    .tag_i      (bus.in_tag),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .flush_i    (bus.flush),
    .result_o   (bus.result),
    .status_o   (bus.status),
    .tag_o      (bus.out_tag),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .busy_o     (bus.busy)
  );

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  tag_t next_tag = 8'd1;

  localparam logic [4:0] NV = 5'h10;
  localparam logic [4:0] NX = 5'h01;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compares every handed-off result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got result %h tag %0d, expected no output",
                   bus.result, bus.out_tag);
        end else begin
          e = sb.pop_front();
          check($sformatf("tag%0d_result", e.tag), bus.result, e.res);
          check($sformatf("tag%0d_status", e.tag), 32'(bus.status), 32'(e.st));
          check($sformatf("tag%0d_tag", e.tag), 32'(bus.out_tag), 32'(e.tag));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] op, input logic [2:0] rm, input logic mod,
                      input logic [31:0] er, input logic [4:0] es, input bit expect_out);
    int waited = 0;
    bus.operand  = op;
    bus.rnd_mode = rm;
    bus.op_mod   = mod;
    bus.in_tag   = next_tag;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: tag %0d in_ready stayed 0, expected 1", next_tag);
    end else if (expect_out) begin
      sb.push_back('{res: er, st: es, tag: next_tag});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    next_tag++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  // Operation driven after edge N must present out_valid after edge N+3.
  task automatic latency_op(input string name);
    send(32'h4020_0000, 3'd0, 1'b0, 32'd2, NX, 1'b1);
    @(negedge clk); check({name, "_lat_n1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk); check({name, "_lat_n2"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk); check({name, "_lat_n3"}, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tag_t bp_tag;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.operand   = '0;
    bus.rnd_mode  = '0;
    bus.op_mod    = 1'b0;
    bus.in_tag    = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rounding modes on 2.5
    send(32'h4020_0000, 3'd0, 1'b0, 32'h0000_0002, NX, 1'b1);
    send(32'h4020_0000, 3'd4, 1'b0, 32'h0000_0003, NX, 1'b1);
    send(32'h4020_0000, 3'd1, 1'b0, 32'h0000_0002, NX, 1'b1);
    send(32'h4020_0000, 3'd3, 1'b0, 32'h0000_0003, NX, 1'b1);
    // -2^31 boundary
    send(32'hCF00_0000, 3'd1, 1'b0, 32'h8000_0000, 5'h00, 1'b1);
    send(32'hCF00_0000, 3'd1, 1'b1, 32'h0000_0000, NV, 1'b1);
    // NaN, overflow, largest unsigned-representable, negative fraction
    send(32'h7FC0_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, NV, 1'b1);
    send(32'h4F80_0000, 3'd0, 1'b1, 32'hFFFF_FFFF, NV, 1'b1);
    send(32'h4F7F_FFFF, 3'd0, 1'b1, 32'hFFFF_FF00, 5'h00, 1'b1);
    send(32'hBE99_999A, 3'd1, 1'b1, 32'h0000_0000, NX, 1'b1);
    send(32'hBE99_999A, 3'd2, 1'b1, 32'h0000_0000, NV, 1'b1);
    // Negative rounding, ties, subnormal, zero, infinities
    send(32'hC020_0000, 3'd2, 1'b0, 32'hFFFF_FFFD, NX, 1'b1);
    send(32'hC020_0000, 3'd0, 1'b0, 32'hFFFF_FFFE, NX, 1'b1);
    send(32'h3F00_0000, 3'd0, 1'b0, 32'h0000_0000, NX, 1'b1);
    send(32'h3F00_0000, 3'd4, 1'b0, 32'h0000_0001, NX, 1'b1);
    send(32'h0000_0001, 3'd3, 1'b0, 32'h0000_0001, NX, 1'b1);
    send(32'h8000_0000, 3'd2, 1'b0, 32'h0000_0000, 5'h00, 1'b1);
    send(32'hFF80_0000, 3'd0, 1'b0, 32'h8000_0000, NV, 1'b1);
    send(32'hFF80_0000, 3'd0, 1'b1, 32'h0000_0000, NV, 1'b1);
    send(32'h4F00_0000, 3'd1, 1'b0, 32'h7FFF_FFFF, NV, 1'b1);
    send(32'hBF80_0000, 3'd0, 1'b1, 32'h0000_0000, NV, 1'b1);
    send(32'h4060_0000, 3'd5, 1'b0, 32'h0000_0004, NX, 1'b1);
    send(32'h3FC0_0000, 3'd2, 1'b0, 32'h0000_0001, NX, 1'b1);
    drain();

    // Backpressure: three fill the pipeline, the rest wait
    bus.out_ready = 1'b0;
    bp_tag = next_tag;
    send(32'h3F80_0000, 3'd0, 1'b0, 32'd1, 5'h00, 1'b1);
    send(32'h4000_0000, 3'd0, 1'b0, 32'd2, 5'h00, 1'b1);
    send(32'h4040_0000, 3'd0, 1'b0, 32'd3, 5'h00, 1'b1);
    bus.operand  = 32'h4080_0000;
    bus.in_tag   = next_tag;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_hold_result_%0d", i), bus.result, 32'd1);
      check($sformatf("bp_hold_tag_%0d", i), 32'(bus.out_tag), 32'(bp_tag));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h4080_0000, 3'd0, 1'b0, 32'd4, 5'h00, 1'b1);
    send(32'h40A0_0000, 3'd0, 1'b0, 32'd5, 5'h00, 1'b1);
    drain();

    // Flush with two operations in flight
    send(32'h4120_0000, 3'd0, 1'b0, 32'd10, 5'h00, 1'b0);
    send(32'h4140_0000, 3'd0, 1'b0, 32'd12, 5'h00, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    latency_op("flush");
    drain();

    // Reset pulse with two operations in flight
    send(32'h4120_0000, 3'd0, 1'b0, 32'd10, 5'h00, 1'b0);
    send(32'h4140_0000, 3'd0, 1'b0, 32'd12, 5'h00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstp_busy", 32'(bus.busy), 32'd0);
    check("rstp_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstp_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    latency_op("rstp");
    drain();

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
